// File: rtl/game_engine_pkg.sv
// Shared types and encodings for the counter game engine: FSM states,
// WHO status codes and the step-select encodings on `control`.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam logic [1:0] WHO_NONE   = 2'b00;
  localparam logic [1:0] WHO_LOSER  = 2'b01;
  localparam logic [1:0] WHO_WINNER = 2'b10;

  // control[1] set means a downward step, which is what the lose check keys on
  localparam logic [1:0] CTRL_INC1 = 2'b00;
  localparam logic [1:0] CTRL_INC2 = 2'b01;
  localparam logic [1:0] CTRL_DEC1 = 2'b10;
  localparam logic [1:0] CTRL_DEC2 = 2'b11;

endpackage

// File: rtl/game_step_counter.sv
// Step counter for the game: synchronous load, +/-1 or +/-2 step with silent
// modulo-2^SIZE wrap, and a hold that freezes the count outside of play.
module game_step_counter
  import game_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            hold_i,
  input  logic            load_i,
  input  logic [SIZE-1:0] load_val_i,
  input  logic [1:0]      control_i,
  output logic [SIZE-1:0] count_o
);

  localparam logic [SIZE-1:0] ONE = SIZE'(1);
  localparam logic [SIZE-1:0] TWO = SIZE'(2);

  logic [SIZE-1:0] count_q, count_d, stepped;

  always_comb begin
    stepped = count_q + ONE;
    case (control_i)
      CTRL_INC2: stepped = count_q + TWO;
      CTRL_DEC1: stepped = count_q - ONE;
      CTRL_DEC2: stepped = count_q - TWO;
      default:   stepped = count_q + ONE;
    endcase
  end

  // A load wins over hold so the start action can preload the count from IDLE/OVER
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (!hold_i) begin
      count_d = stepped;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/game_engine.sv
// Counter game engine: IDLE/PLAY/OVER FSM, win/lose event detection, score
// counters against a latched target, and start/ack or auto-restart handshake.
module game_engine
  import game_pkg::*;
#(
  parameter int SIZE         = 4,
  parameter int SCORE_W      = 4,
  parameter int AUTO_RESTART = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               ack,
  input  logic               INIT_c,
  input  logic [SIZE-1:0]    INIT_l,
  input  logic [1:0]         control,
  input  logic [SCORE_W-1:0] target,
  output logic [SIZE-1:0]    count,
  output logic               WINNER,
  output logic               LOSER,
  output logic [SCORE_W-1:0] w_count,
  output logic [SCORE_W-1:0] l_count,
  output logic               GAMEOVER,
  output logic [1:0]         WHO,
  output logic [1:0]         state
);

  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
  localparam logic               AUTO      = (AUTO_RESTART != 0);

  game_state_t        state_q, state_d;
  logic [SCORE_W-1:0] w_count_q, w_count_d, l_count_q, l_count_d;
  logic [SCORE_W-1:0] target_q, target_d, w_inc, l_inc;
  logic               winner_q, winner_d, loser_q, loser_d;
  logic               gameover_q, gameover_d;
  logic [1:0]         who_q, who_d;
  logic               in_play, start_act, win_ev, lose_ev, win_final, lose_final;
  logic               cnt_load;
  logic [SIZE-1:0]    cnt_load_val;

  assign in_play   = (state_q == PLAY);
  assign start_act = ((state_q == IDLE) && start) || ((state_q == OVER) && AUTO);

  // Events look at the registered count; a pulse in flight blocks detection for a cycle
  assign win_ev     = in_play && (count == '1) && !control[1] && !winner_q && !loser_q;
  assign lose_ev    = in_play && (count == '0) && control[1] && !winner_q && !loser_q;
  assign w_inc      = w_count_q + SCORE_ONE;
  assign l_inc      = l_count_q + SCORE_ONE;
  assign win_final  = win_ev && (w_inc == target_q);
  assign lose_final = lose_ev && (l_inc == target_q);

  assign cnt_load     = start_act || (in_play && INIT_c);
  assign cnt_load_val = INIT_c ? INIT_l : '0;

  game_step_counter #(.SIZE(SIZE)) u_counter (
    .clk_i      (clk),
    .rst_ni     (reset),
    .hold_i     (!in_play),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .control_i  (control),
    .count_o    (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = PLAY;
      PLAY:    if (win_final || lose_final) state_d = OVER;
      OVER:    if (AUTO) state_d = PLAY;
               else if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    winner_d   = 1'b0;
    loser_d    = 1'b0;
    w_count_d  = w_count_q;
    l_count_d  = l_count_q;
    target_d   = target_q;
    gameover_d = gameover_q;
    who_d      = who_q;
    if (start_act) begin
      w_count_d  = '0;
      l_count_d  = '0;
      target_d   = (target == '0) ? SCORE_ONE : target;
      gameover_d = 1'b0;
      who_d      = WHO_NONE;
    end else if (win_ev) begin
      winner_d  = 1'b1;
      w_count_d = w_inc;
      if (win_final) begin
        gameover_d = 1'b1;
        who_d      = WHO_WINNER;
      end
    end else if (lose_ev) begin
      loser_d   = 1'b1;
      l_count_d = l_inc;
      if (lose_final) begin
        gameover_d = 1'b1;
        who_d      = WHO_LOSER;
      end
    end else if ((state_q == OVER) && ack) begin
      gameover_d = 1'b0;
      who_d      = WHO_NONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      winner_q   <= 1'b0;
      loser_q    <= 1'b0;
      w_count_q  <= '0;
      l_count_q  <= '0;
      target_q   <= SCORE_ONE;
      gameover_q <= 1'b0;
      who_q      <= WHO_NONE;
    end else begin
      winner_q   <= winner_d;
      loser_q    <= loser_d;
      w_count_q  <= w_count_d;
      l_count_q  <= l_count_d;
      target_q   <= target_d;
      gameover_q <= gameover_d;
      who_q      <= who_d;
    end
  end

  assign WINNER   = winner_q;
  assign LOSER    = loser_q;
  assign w_count  = w_count_q;
  assign l_count  = l_count_q;
  assign GAMEOVER = gameover_q;
  assign WHO      = who_q;
  assign state    = state_q;

endmodule

// File: tb/tb_game_engine.sv
// Bench for game_engine: a handshake instance and an auto-restart instance run
// side by side against a behavioural game model, with directed and random play.
module tb_game_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, ack = 1'b0, INIT_c = 1'b0;
  logic [3:0] INIT_l = '0;
  logic [1:0] control = '0;
  logic [3:0] target = '0;

  logic [3:0] c0, wc0, lc0, c1, wc1, lc1;
  logic       W0, L0, go0, W1, L1, go1;
  logic [1:0] who0, st0, who1, st1;

  always #5 clk = ~clk;

  game_engine #(.SIZE(4), .SCORE_W(4), .AUTO_RESTART(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .ack(ack), .INIT_c(INIT_c),
    .INIT_l(INIT_l), .control(control), .target(target), .count(c0),
    .WINNER(W0), .LOSER(L0), .w_count(wc0), .l_count(lc0), .GAMEOVER(go0),
    .WHO(who0), .state(st0));

  game_engine #(.SIZE(4), .SCORE_W(4), .AUTO_RESTART(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .ack(ack), .INIT_c(INIT_c),
    .INIT_l(INIT_l), .control(control), .target(target), .count(c1),
    .WINNER(W1), .LOSER(L1), .w_count(wc1), .l_count(lc1), .GAMEOVER(go1),
    .WHO(who1), .state(st1));

  // st: 0 idle, 1 play, 2 over; who: 0 none, 1 loser, 2 winner
  typedef struct {
    int st; int cnt; int w; int l; int tgt; int win; int lose; int go; int who;
  } mdl_t;

  mdl_t m0, m1;
  int   n_pass = 0;
  int   n_total = 0;

  function automatic mdl_t mreset();
    mdl_t m;
    m.st = 0; m.cnt = 0; m.w = 0; m.l = 0; m.tgt = 1;
    m.win = 0; m.lose = 0; m.go = 0; m.who = 0;
    return m;
  endfunction

  function automatic mdl_t mbegin(mdl_t m);
    mdl_t n = m;
    n.st = 1;
    n.cnt = INIT_c ? int'(INIT_l) : 0;
    n.w = 0; n.l = 0;
    n.tgt = (target == 0) ? 1 : int'(target);
    n.win = 0; n.lose = 0; n.go = 0; n.who = 0;
    return n;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int auto_rs);
    mdl_t n;
    int   delta;
    int   quiet;
    n = m;
    n.win = 0;
    n.lose = 0;
    delta = (control == 0) ? 1 : (control == 1) ? 2 : (control == 2) ? -1 : -2;
    quiet = (m.win == 0 && m.lose == 0) ? 1 : 0;
    if (m.st == 0) begin
      if (start) n = mbegin(m);
    end else if (m.st == 1) begin
      n.cnt = INIT_c ? int'(INIT_l) : (m.cnt + delta + 16) % 16;
      if (quiet == 1 && control[1] == 1'b0 && m.cnt == 15) begin
        n.win = 1;
        n.w = m.w + 1;
        if (n.w == m.tgt) begin n.st = 2; n.go = 1; n.who = 2; end
      end
      if (quiet == 1 && control[1] == 1'b1 && m.cnt == 0) begin
        n.lose = 1;
        n.l = m.l + 1;
        if (n.l == m.tgt) begin n.st = 2; n.go = 1; n.who = 1; end
      end
    end else begin
      if (auto_rs != 0) n = mbegin(m);
      else if (ack) begin n.st = 0; n.go = 0; n.who = 0; end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_dut(input string ph);
    chk({ph, ".d0.count"}, 32'(c0), m0.cnt);
    chk({ph, ".d0.WINNER"}, 32'(W0), m0.win);
    chk({ph, ".d0.LOSER"}, 32'(L0), m0.lose);
    chk({ph, ".d0.w_count"}, 32'(wc0), m0.w);
    chk({ph, ".d0.l_count"}, 32'(lc0), m0.l);
    chk({ph, ".d0.GAMEOVER"}, 32'(go0), m0.go);
    chk({ph, ".d0.WHO"}, 32'(who0), m0.who);
    chk({ph, ".d0.state"}, 32'(st0), m0.st);
    chk({ph, ".d1.count"}, 32'(c1), m1.cnt);
    chk({ph, ".d1.WINNER"}, 32'(W1), m1.win);
    chk({ph, ".d1.LOSER"}, 32'(L1), m1.lose);
    chk({ph, ".d1.w_count"}, 32'(wc1), m1.w);
    chk({ph, ".d1.l_count"}, 32'(lc1), m1.l);
    chk({ph, ".d1.GAMEOVER"}, 32'(go1), m1.go);
    chk({ph, ".d1.WHO"}, 32'(who1), m1.who);
    chk({ph, ".d1.state"}, 32'(st1), m1.st);
  endtask

  task automatic cyc(input string ph);
    m0 = mstep(m0, 0);
    m1 = mstep(m1, 1);
    @(posedge clk);
    #1;
    check_dut(ph);
  endtask

  // Reset is asserted between edges and checked before the next edge arrives
  task automatic do_reset(input string ph);
    reset = 1'b0;
    #1;
    m0 = mreset();
    m1 = mreset();
    check_dut(ph);
    @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b0;
    ack = 1'b0;
    INIT_c = 1'b0;
  endtask

  initial begin
    #2;
    do_reset("por");

    // Count up from 13 to the single winning event
    INIT_c = 1'b1; INIT_l = 4'd13; control = 2'b00; target = 4'd1; start = 1'b1;
    cyc("win");
    start = 1'b0; INIT_c = 1'b0;
    chk("win.load", 32'(c0), 13);
    cyc("win");
    cyc("win");
    chk("win.c15", 32'(c0), 15);
    cyc("win");
    chk("win.pulse", 32'(W0), 1);
    chk("win.wcnt", 32'(wc0), 1);
    chk("win.over", 32'(go0), 1);
    chk("win.who", 32'(who0), 2);
    chk("win.state", 32'(st0), 2);
    chk("ar.over", 32'(go1), 1);

    // Handshake holds OVER while auto-restart leaves after one cycle
    for (int i = 0; i < 5; i++) begin
      cyc("hold");
      chk("hold.go", 32'(go0), 1);
      chk("hold.state", 32'(st0), 2);
      if (i == 0) begin
        chk("ar.go", 32'(go1), 0);
        chk("ar.state", 32'(st1), 1);
        chk("ar.wcnt", 32'(wc1), 0);
      end
    end
    ack = 1'b1;
    cyc("ack");
    ack = 1'b0;
    chk("ack.state", 32'(st0), 0);
    chk("ack.go", 32'(go0), 0);

    // Steps of -2 from an odd count skip zero forever
    do_reset("rst2");
    INIT_c = 1'b1; INIT_l = 4'd3; control = 2'b11; target = 4'd1; start = 1'b1;
    cyc("skip");
    start = 1'b0; INIT_c = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc("skip");
      chk("skip.nolose", 32'(L0), 0);
    end

    // Two losses needed, second one after a full wrap
    do_reset("rst3");
    INIT_c = 1'b1; INIT_l = 4'd2; control = 2'b10; target = 4'd2; start = 1'b1;
    cyc("down");
    start = 1'b0; INIT_c = 1'b0;
    cyc("down");
    cyc("down");
    cyc("down");
    chk("down.lose1", 32'(L0), 1);
    chk("down.l1", 32'(lc0), 1);
    chk("down.wrap", 32'(c0), 15);
    chk("down.go1", 32'(go0), 0);
    for (int i = 0; i < 15; i++) cyc("down");
    chk("down.c0", 32'(c0), 0);
    cyc("down");
    chk("down.lose2", 32'(L0), 1);
    chk("down.l2", 32'(lc0), 2);
    chk("down.go2", 32'(go0), 1);
    chk("down.who", 32'(who0), 1);

    // Zero target behaves as one
    do_reset("rst4");
    INIT_c = 1'b1; INIT_l = 4'd14; control = 2'b00; target = 4'd0; start = 1'b1;
    cyc("t0");
    start = 1'b0; INIT_c = 1'b0;
    cyc("t0");
    cyc("t0");
    chk("t0.pulse", 32'(W0), 1);
    chk("t0.over", 32'(go0), 1);
    chk("t0.who", 32'(who0), 2);

    // Count parked at all-ones by reload: pulse every other cycle
    do_reset("rst5");
    INIT_c = 1'b1; INIT_l = 4'd15; control = 2'b00; target = 4'd15; start = 1'b1;
    cyc("park");
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc("park");
      chk("park.pulse", 32'(W0), (i % 2 == 0) ? 1 : 0);
    end
    INIT_c = 1'b0;

    // Asynchronous reset in the middle of play
    do_reset("rst6");
    INIT_c = 1'b1; INIT_l = 4'd9; control = 2'b00; target = 4'd3; start = 1'b1;
    cyc("mid");
    start = 1'b0; INIT_c = 1'b0;
    chk("mid.c9", 32'(c0), 9);
    do_reset("async");
    chk("async.count", 32'(c0), 0);
    chk("async.state", 32'(st0), 0);

    // Random play against the model
    for (int i = 0; i < 600; i++) begin
      start   = ($urandom_range(0, 3) == 0);
      ack     = ($urandom_range(0, 2) == 0);
      INIT_c  = ($urandom_range(0, 7) == 0);
      INIT_l  = 4'($urandom);
      control = 2'($urandom);
      target  = 4'($urandom_range(0, 3));
      cyc("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
